// File: rtl/shift_seq_if.sv
// shift_seq_if: start/done request bus between the CPU control unit and the iterative shifter.
interface shift_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] res;
    logic        stall;
    modport master (output start, op, A, shamt, input busy, done, res, stall);
    modport slave  (input start, op, A, shamt, output busy, done, res, stall);
endinterface

// File: rtl/shift_seq.sv
// shift_seq: multi-cycle sll/srl/sra unit shifting up to STEP bits per cycle.
// Define SHIFT_ROTATE_EN to make op=11 rotate right; otherwise op=11 behaves as srl.
module shift_seq #(
    parameter int STEP = 1
) (
    input logic       clk,
    input logic       rst,
    shift_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [5:0] STEP6 = 6'(STEP);
    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d, res_q, res_d, sh_v, srl_v;
    logic [4:0]  rem_q, rem_d;
    logic [1:0]  op_q, op_d;
    logic        done_q, busy_q;
    logic [5:0]  k;
    // 6-bit compare so STEP=32 cannot wrap against the 5-bit remainder
    assign k = ({1'b0, rem_q} < STEP6) ? {1'b0, rem_q} : STEP6;
`ifdef SHIFT_ROTATE_EN
    assign srl_v = op_q == 2'b11 ? (acc_q >> k) | (acc_q << (6'd32 - k)) : acc_q >> k;
`else
    assign srl_v = acc_q >> k;
`endif
    assign sh_v = op_q == 2'b00 ? acc_q << k :
                  op_q == 2'b10 ? 32'($signed(acc_q) >>> k) : srl_v;
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        op_d    = op_q;
        if (state_q == IDLE && bus.start) begin
            acc_d   = bus.A;
            rem_d   = bus.shamt;
            op_d    = bus.op;
            state_d = bus.shamt == 5'd0 ? DONE : RUN;
        end else if (state_q == RUN) begin
            acc_d   = sh_v;
            rem_d   = rem_q - k[4:0];
            state_d = ({1'b0, rem_q} <= STEP6) ? DONE : RUN;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    // DONE is only ever entered from IDLE or RUN, so this captures the final acc once
    assign res_d = state_d == DONE ? acc_d : res_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            res_q   <= res_d;
            done_q  <= state_d == DONE;
            busy_q  <= state_d != IDLE;
        end
    end
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.res   = res_q;
    assign bus.stall = (state_q == IDLE && bus.start) || state_q == RUN;
endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: four shifters (STEP 1/4/8/32) on shared stimulus, checked every cycle against a whole-shift model.
module tb_shift_seq;
    localparam int NS = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] A = '0;
    logic [4:0]  shamt = '0;
    logic        busy_w [NS];
    logic        done_w [NS];
    logic        stall_w [NS];
    logic [31:0] res_w [NS];
    int n_chk = 0, n_fail = 0;
    int left [NS];
    bit [31:0] pend [NS];
    bit [31:0] eres [NS];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NS; g++) begin : gd
        localparam int ST = g == 0 ? 1 : g == 1 ? 4 : g == 2 ? 8 : 32;
        shift_seq_if ifc ();
        assign ifc.start = start;
        assign ifc.op    = op;
        assign ifc.A     = A;
        assign ifc.shamt = shamt;
        assign busy_w[g]  = ifc.busy;
        assign done_w[g]  = ifc.done;
        assign stall_w[g] = ifc.stall;
        assign res_w[g]   = ifc.res;
        shift_seq #(.STEP(ST)) dut (.clk(clk), .rst(rst), .bus(ifc));
    end

    function automatic int step_of(int i);
        return i == 0 ? 1 : i == 1 ? 4 : i == 2 ? 8 : 32;
    endfunction

    function automatic logic [31:0] ref_shift(logic [1:0] o, logic [31:0] a, logic [4:0] s);
`ifdef SHIFT_ROTATE_EN
        logic [63:0] d;
        d = {a, a} >> s;
        if (o == 2'b11) return d[31:0];
`endif
        if (o == 2'b00) return a << s;
        if (o == 2'b10) return 32'($signed(a) >>> s);
        return a >> s;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // left = cycles still to spend outside IDLE, including the DONE cycle
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < NS; i++) begin
            if (rst) begin
                left[i] = 0;
                eres[i] = '0;
            end else if (left[i] > 0) begin
                left[i]--;
            end else if (start) begin
                left[i] = (int'(shamt) + step_of(i) - 1) / step_of(i) + 1;
                pend[i] = ref_shift(op, A, shamt);
            end
            if (!rst && left[i] == 1) eres[i] = pend[i];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            chk($sformatf("busy%0d", i), 32'(busy_w[i]), 32'(left[i] > 0));
            chk($sformatf("done%0d", i), 32'(done_w[i]), 32'(left[i] == 1));
            chk($sformatf("stall%0d", i), 32'(stall_w[i]), 32'((left[i] == 0 && start) || left[i] > 1));
            chk($sformatf("res%0d", i), res_w[i], eres[i]);
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_w[0] || busy_w[1] || busy_w[2] || busy_w[3]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n >= 100), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic directed(int idx, logic [1:0] o, logic [31:0] a, logic [4:0] s,
                            logic [31:0] exp_res, int exp_cyc);
        int got;
        got = 0;
        start = 1'b1; op = o; A = a; shamt = s;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 60 && got == 0; c++) begin
            @(negedge clk);
            if (done_w[idx]) got = c;
            else @(posedge clk);
        end
        chk($sformatf("lit_cyc%0d_%h", idx, a), 32'(got), 32'(exp_cyc));
        chk($sformatf("lit_res%0d_%h", idx, a), res_w[idx], exp_res);
        wait_idle();
    endtask

    initial begin
        int ndone, dc;
        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        directed(0, 2'b00, 32'h0000_0001, 5'd5, 32'h0000_0020, 6);
        directed(0, 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32);
        directed(0, 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 32);
        directed(1, 2'b01, 32'hF000_0000, 5'd6, 32'h03C0_0000, 3);
        directed(1, 2'b01, 32'h1234_5678, 5'd0, 32'h1234_5678, 1);
        directed(3, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 2);
`ifdef SHIFT_ROTATE_EN
        directed(2, 2'b11, 32'h1234_5678, 5'd12, 32'h6781_2345, 3);
`else
        directed(2, 2'b11, 32'h1234_5678, 5'd12, 32'h0001_2345, 3);
`endif
        // start held high while STEP=1 unit is busy must not re-latch
        ndone = 0; dc = 0;
        start = 1'b1; op = 2'b00; A = 32'h0000_0003; shamt = 5'd8;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            #1;
            start = c >= 2 && c <= 9;
            A = 32'hFFFF_FFFF; shamt = 5'd1;
            @(negedge clk);
            if (done_w[0]) begin ndone++; dc = c; end
            @(posedge clk);
        end
        #1 start = 1'b0;
        chk("hold_ndone", 32'(ndone), 32'd1);
        chk("hold_cyc", 32'(dc), 32'd9);
        chk("hold_res", res_w[0], 32'h0000_0300);
        wait_idle();
        // reset in cycle 3 of a 20-bit shift
        start = 1'b1; op = 2'b10; A = 32'h8765_4321; shamt = 5'd20;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < NS; i++) begin
            chk($sformatf("rst_busy%0d", i), 32'(busy_w[i]), 32'd0);
            chk($sformatf("rst_done%0d", i), 32'(done_w[i]), 32'd0);
            chk($sformatf("rst_stall%0d", i), 32'(stall_w[i]), 32'd0);
            chk($sformatf("rst_res%0d", i), res_w[i], 32'd0);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        directed(0, 2'b00, 32'h0000_00FF, 5'd4, 32'h0000_0FF0, 5);
        for (int c = 0; c < 400; c++) begin
            start = $urandom_range(0, 2) == 0;
            op = 2'($urandom_range(0, 3));
            A = $urandom;
            shamt = 5'($urandom_range(0, 31));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
